// File: rtl/execute_stage_mc_if.sv
// Handshake and data bundle between the ID/EX register, the execute stage
// and the memory stage. The master drives instructions in and consumes the
// EX/MEM result; the slave is the execute stage itself.
interface execute_stage_mc_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int RA_W   = 3,
  parameter int SB_W   = 8
);
  // Instruction side
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_op;
  logic [3:0]        shamt;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic [DATA_W-1:0] ex_mem_data;
  logic [DATA_W-1:0] mem_wb_data;
  logic              flag_en;
  logic [2:0]        jump_sel;
  logic [PC_W-1:0]   pc_in;
  logic [RA_W-1:0]   wr_addr_in;
  logic [SB_W-1:0]   sb_in;

  // Pipeline control
  logic              flush;
  logic              flag_restore;
  logic [2:0]        flags_in;

  // Result side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result_out;
  logic [2:0]        flags_out;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   pc_out;
  logic [RA_W-1:0]   wr_addr_out;
  logic [SB_W-1:0]   sb_out;

  modport master (
    output in_valid, alu_op, shamt, src1, src2, fwd_sel1, fwd_sel2,
           ex_mem_data, mem_wb_data, flag_en, jump_sel, pc_in, wr_addr_in,
           sb_in, flush, flag_restore, flags_in, out_ready,
    input  in_ready, out_valid, result_out, flags_out, branch_taken,
           branch_target, pc_out, wr_addr_out, sb_out
  );

  modport slave (
    input  in_valid, alu_op, shamt, src1, src2, fwd_sel1, fwd_sel2,
           ex_mem_data, mem_wb_data, flag_en, jump_sel, pc_in, wr_addr_in,
           sb_in, flush, flag_restore, flags_in, out_ready,
    output in_ready, out_valid, result_out, flags_out, branch_taken,
           branch_target, pc_out, wr_addr_out, sb_out
  );
endinterface

// File: rtl/execute_stage_mc.sv
// Multi-cycle execute stage: operand forwarding, single-cycle ALU, iterative
// shift-add multiplier, CNZ flag register, branch evaluation and a
// valid/ready EX/MEM output register with stall and flush support.
module execute_stage_mc #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int RA_W   = 3,
  parameter int SB_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  execute_stage_mc_if.slave  bus
);

  // FSM encoding
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;

  // ALU operation codes
  localparam logic [3:0] OP_PASS1 = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_INC   = 4'b1001;
  localparam logic [3:0] OP_DEC   = 4'b1010;
  localparam logic [3:0] OP_PASS2 = 4'b1011;

  // Step counter runs 0..DATA_W-1; the last step is merged with the load.
  localparam int             CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Flag bit positions inside {C,N,Z}
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_mcand;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_mplier;

  // Instruction context held while the multiplier iterates
  logic                r_m_flag_en;
  logic                r_m_branch;
  logic [PC_W-1:0]     r_m_target;
  logic [PC_W-1:0]     r_m_pc;
  logic [RA_W-1:0]     r_m_wr_addr;
  logic [SB_W-1:0]     r_m_sb;

  // EX/MEM output register and flags
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_result;
  logic [2:0]          r_flags;
  logic                r_branch_taken;
  logic [PC_W-1:0]     r_branch_target;
  logic [PC_W-1:0]     r_pc_out;
  logic [RA_W-1:0]     r_wr_addr_out;
  logic [SB_W-1:0]     r_sb_out;

  // ---------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_op2;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_is_mul;
  logic                w_branch;
  logic [PC_W-1:0]     w_target;

  logic [DATA_W:0]     w_add;
  logic [DATA_W:0]     w_sub;
  logic [DATA_W:0]     w_inc;
  logic [DATA_W:0]     w_dec;
  logic [DATA_W:0]     w_shl;
  logic [DATA_W:0]     w_shr;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_c;
  logic                w_alu_upd;

  logic [2*DATA_W-1:0] w_mul_addend;
  logic [2*DATA_W-1:0] w_acc_nxt;
  logic                w_mul_done;

  logic                w_load;
  logic [DATA_W-1:0]   w_ld_res;
  logic                w_ld_c;
  logic                w_ld_upd;
  logic                w_ld_flag_en;
  logic                w_ld_branch;
  logic [PC_W-1:0]     w_ld_target;
  logic [PC_W-1:0]     w_ld_pc;
  logic [RA_W-1:0]     w_ld_wr_addr;
  logic [SB_W-1:0]     w_ld_sb;

  // Forwarding muxes: 01 picks EX/MEM, 10 picks MEM/WB, 00/11 the regfile.
  always_comb begin
    case (bus.fwd_sel1)
      2'b01:   w_op1 = bus.ex_mem_data;
      2'b10:   w_op1 = bus.mem_wb_data;
      default: w_op1 = bus.src1;
    endcase
    case (bus.fwd_sel2)
      2'b01:   w_op2 = bus.ex_mem_data;
      2'b10:   w_op2 = bus.mem_wb_data;
      default: w_op2 = bus.src2;
    endcase
  end

  // Accept only when idle, the output slot is free or draining, and no flush.
  assign w_in_ready = reset && (r_state == S_IDLE)
                    && (!r_out_valid || bus.out_ready) && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.alu_op == OP_MUL);
  assign w_target   = PC_W'(w_op1);

  // Branch decision uses the flags as they stand before this op updates them.
  always_comb begin
    case (bus.jump_sel)
      3'b001:  w_branch = r_flags[FLAG_Z];
      3'b010:  w_branch = r_flags[FLAG_N];
      3'b011:  w_branch = r_flags[FLAG_C];
      3'b100:  w_branch = 1'b1;
      default: w_branch = 1'b0;
    endcase
  end

  // Extended-width arithmetic exposes carry/borrow/shifted-out bit on top.
  assign w_add = {1'b0, w_op1} + {1'b0, w_op2};
  assign w_sub = {1'b0, w_op1} - {1'b0, w_op2};
  assign w_inc = {1'b0, w_op1} + (DATA_W+1)'(1);
  assign w_dec = {1'b0, w_op1} - (DATA_W+1)'(1);
  assign w_shl = {1'b0, w_op1} << bus.shamt;
  assign w_shr = {w_op1, 1'b0} >> bus.shamt;

  // Single-cycle ALU result, candidate carry and whether flags may change.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_alu_res = w_op1;
    w_alu_c   = r_flags[FLAG_C];
    w_alu_upd = 1'b1;
    case (bus.alu_op)
      OP_PASS1: w_alu_res = w_op1;
      OP_ADD:   begin w_alu_res = w_add[DATA_W-1:0]; w_alu_c = w_add[DATA_W]; end
      OP_SUB:   begin w_alu_res = w_sub[DATA_W-1:0]; w_alu_c = w_sub[DATA_W]; end
      OP_AND:   w_alu_res = w_op1 & w_op2;
      OP_OR:    w_alu_res = w_op1 | w_op2;
      OP_NOT:   w_alu_res = ~w_op1;
      OP_SHL: begin
        w_alu_res = w_shl[DATA_W-1:0];
        if (bus.shamt != 4'd0) w_alu_c = w_shl[DATA_W];
      end
      OP_SHR: begin
        w_alu_res = w_shr[DATA_W:1];
        if (bus.shamt != 4'd0) w_alu_c = w_shr[0];
      end
      OP_INC:   begin w_alu_res = w_inc[DATA_W-1:0]; w_alu_c = w_inc[DATA_W]; end
      OP_DEC:   begin w_alu_res = w_dec[DATA_W-1:0]; w_alu_c = w_dec[DATA_W]; end
      OP_PASS2: w_alu_res = w_op2;
      default:  begin w_alu_res = w_op1; w_alu_upd = 1'b0; end
    endcase
  end

  // One shift-add step; on the final step this sum is the full product.
  assign w_mul_addend = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt    = r_acc + w_mul_addend;
  assign w_mul_done   = (r_state == S_MUL_BUSY) && (r_cnt == CNT_LAST);

  // A flush kills whatever would have loaded on this edge.
  assign w_load = !bus.flush && ((w_accept && !w_is_mul) || w_mul_done);

  // Select what loads into the output register: finishing MUL or live op.
  always_comb begin
    if (r_state == S_MUL_BUSY) begin
      w_ld_res     = w_acc_nxt[DATA_W-1:0];
      w_ld_c       = |w_acc_nxt[2*DATA_W-1:DATA_W];
      w_ld_upd     = 1'b1;
      w_ld_flag_en = r_m_flag_en;
      w_ld_branch  = r_m_branch;
      w_ld_target  = r_m_target;
      w_ld_pc      = r_m_pc;
      w_ld_wr_addr = r_m_wr_addr;
      w_ld_sb      = r_m_sb;
    end else begin
      w_ld_res     = w_alu_res;
      w_ld_c       = w_alu_c;
      w_ld_upd     = w_alu_upd;
      w_ld_flag_en = bus.flag_en;
      w_ld_branch  = w_branch;
      w_ld_target  = w_target;
      w_ld_pc      = bus.pc_in;
      w_ld_wr_addr = bus.wr_addr_in;
      w_ld_sb      = bus.sb_in;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Control FSM: IDLE <-> MUL_BUSY with the step counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= S_MUL_BUSY;
            r_cnt   <= '0;
          end
        end
        S_MUL_BUSY: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Multiplier operands, accumulator and the held instruction context.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_m_flag_en <= 1'b0;
      r_m_branch  <= 1'b0;
      r_m_target  <= '0;
      r_m_pc      <= '0;
      r_m_wr_addr <= '0;
      r_m_sb      <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_is_mul) begin
        r_mcand     <= {{DATA_W{1'b0}}, w_op1};
        r_mplier    <= w_op2;
        r_acc       <= '0;
        r_m_flag_en <= bus.flag_en;
        r_m_branch  <= w_branch;
        r_m_target  <= w_target;
        r_m_pc      <= bus.pc_in;
        r_m_wr_addr <= bus.wr_addr_in;
        r_m_sb      <= bus.sb_in;
      end
    end else begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // EX/MEM output register: load beats drain, flush beats both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid     <= 1'b0;
      r_result        <= '0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_pc_out        <= '0;
      r_wr_addr_out   <= '0;
      r_sb_out        <= '0;
    end else if (bus.flush) begin
      r_out_valid    <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (w_load) begin
      r_out_valid     <= 1'b1;
      r_result        <= w_ld_res;
      r_branch_taken  <= w_ld_branch;
      r_branch_target <= w_ld_target;
      r_pc_out        <= w_ld_pc;
      r_wr_addr_out   <= w_ld_wr_addr;
      r_sb_out        <= w_ld_sb;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Flag register: restore beats flush, flush beats the op's own update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 3'b000;
    end else if (bus.flag_restore) begin
      r_flags <= bus.flags_in;
    end else if (w_load && w_ld_flag_en && w_ld_upd) begin
      r_flags <= {w_ld_c, w_ld_res[DATA_W-1], (w_ld_res == '0)};
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.result_out    = r_result;
  assign bus.flags_out     = r_flags;
  assign bus.branch_taken  = r_branch_taken;
  assign bus.branch_target = r_branch_target;
  assign bus.pc_out        = r_pc_out;
  assign bus.wr_addr_out   = r_wr_addr_out;
  assign bus.sb_out        = r_sb_out;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: a reference model predicts each
// result at acceptance and queues it; a monitor pops and compares on every
// EX/MEM transfer. Directed sections cover reset, latency, forwarding,
// backpressure, branches, flush and reset during a multiply.
module tb_execute_stage_mc;

  localparam int DW  = 16;
  localparam int PW  = 32;
  localparam int RW  = 3;
  localparam int SW  = 8;

  typedef struct {
    logic [DW-1:0] res;
    logic [2:0]    flags;
    logic          br;
    logic [PW-1:0] tgt;
    logic [PW-1:0] pc;
    logic [RW-1:0] wr;
    logic [SW-1:0] sb;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seq      = 0;
  logic [2:0] m_flags = 3'b000;
  exp_t q[$];

  execute_stage_mc_if #(.DATA_W(DW), .PC_W(PW), .RA_W(RW), .SB_W(SW)) bus ();

  execute_stage_mc #(.DATA_W(DW), .PC_W(PW), .RA_W(RW), .SB_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference ALU: result and next {C,N,Z} from the architectural definition.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, b,
                                input logic [3:0] sh, input logic [2:0] f,
                                input logic fen, output logic [15:0] r,
                                output logic [2:0] nf);
    logic [31:0] ua, ub, t;
    logic c, upd;
    ua = {16'h0, a}; ub = {16'h0, b}; c = f[2]; upd = 1'b1; r = a;
    case (op)
      4'd0:  r = a;
      4'd1:  begin t = ua + ub; r = t[15:0]; c = (t > 32'hFFFF); end
      4'd2:  begin r = a - b; c = (ua < ub); end
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = ~a;
      4'd6:  begin t = ua << sh; r = t[15:0]; if (sh != 0) c = t[16]; end
      4'd7:  begin r = a >> sh; if (sh != 0) begin t = ua >> (sh - 4'd1); c = t[0]; end end
      4'd8:  begin t = ua * ub; r = t[15:0]; c = (t[31:16] != 16'h0); end
      4'd9:  begin r = a + 16'd1; c = (a == 16'hFFFF); end
      4'd10: begin r = a - 16'd1; c = (a == 16'h0000); end
      4'd11: r = b;
      default: begin r = a; upd = 1'b0; end
    endcase
    nf = (fen && upd) ? {c, r[15], (r == 16'h0)} : f;
  endfunction

  function automatic logic br_model(input logic [2:0] js, input logic [2:0] f);
    case (js)
      3'b001:  return f[0];
      3'b010:  return f[1];
      3'b011:  return f[2];
      3'b100:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] fwd(input logic [1:0] s, input logic [15:0] rf,
                                      input logic [15:0] exm, input logic [15:0] mwb);
    if (s == 2'b01) return exm;
    if (s == 2'b10) return mwb;
    return rf;
  endfunction

  // Present one instruction, wait (bounded) for acceptance, queue expectation.
  // Returns at 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] sh, input logic fen, input logic [2:0] js,
                      input logic [1:0] s1 = 2'b00, input logic [1:0] s2 = 2'b00,
                      input logic [15:0] exm = 16'h0, input logic [15:0] mwb = 16'h0);
    exp_t e;
    logic [15:0] o1, o2;
    logic accepted;
    int waited;
    bus.alu_op = op; bus.src1 = a; bus.src2 = b; bus.shamt = sh;
    bus.flag_en = fen; bus.jump_sel = js; bus.fwd_sel1 = s1; bus.fwd_sel2 = s2;
    bus.ex_mem_data = exm; bus.mem_wb_data = mwb;
    bus.pc_in = 32'h1000 + 32'(seq * 4); bus.wr_addr_in = 3'(seq); bus.sb_in = 8'(seq * 7);
    bus.in_valid = 1'b1;
    accepted = 1'b0; waited = 0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        o1 = fwd(s1, a, exm, mwb);
        o2 = fwd(s2, b, exm, mwb);
        e.br  = br_model(js, m_flags);
        model(op, o1, o2, sh, m_flags, fen, e.res, e.flags);
        m_flags = e.flags;
        e.tgt = {16'h0, o1};
        e.pc = bus.pc_in; e.wr = bus.wr_addr_in; e.sb = bus.sb_in;
        q.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    seq++;
    check("accept", 64'(accepted), 1);
  endtask

  // Count idle negedges until out_valid rises; also count in_ready=1 while busy.
  task automatic busy_cycles(output int n, output int ir_bad);
    n = 0; ir_bad = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) ir_bad++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compare on every completed EX/MEM transfer.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("sb_result", 64'(bus.result_out), 64'(e.res));
        check("sb_flags",  64'(bus.flags_out), 64'(e.flags));
        check("sb_branch", 64'(bus.branch_taken), 64'(e.br));
        check("sb_target", 64'(bus.branch_target), 64'(e.tgt));
        check("sb_pc",     64'(bus.pc_out), 64'(e.pc));
        check("sb_wr",     64'(bus.wr_addr_out), 64'(e.wr));
        check("sb_sb",     64'(bus.sb_out), 64'(e.sb));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, bad;
    logic [15:0] held;
    logic [2:0]  saved;

    reset = 1'b0;
    bus.in_valid = 0; bus.alu_op = 0; bus.shamt = 0; bus.src1 = 0; bus.src2 = 0;
    bus.fwd_sel1 = 0; bus.fwd_sel2 = 0; bus.ex_mem_data = 0; bus.mem_wb_data = 0;
    bus.flag_en = 0; bus.jump_sel = 0; bus.pc_in = 0; bus.wr_addr_in = 0; bus.sb_in = 0;
    bus.flush = 0; bus.flag_restore = 0; bus.flags_in = 0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_flags",     64'(bus.flags_out), 0);
    check("rst_in_ready",  64'(bus.in_ready), 0);
    check("rst_result",    64'(bus.result_out), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(bus.in_ready), 1);
    @(posedge clk); #1;

    // ADD overflow, latency 1
    send(4'd1, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 3'b000);
    busy_cycles(n, bad);
    check("add_wait",  64'(n), 0);
    check("add_res",   64'(bus.result_out), 64'h0000);
    check("add_flags", 64'(bus.flags_out), 64'b101);
    @(posedge clk); #1;

    // Forwarding from EX/MEM and MEM/WB into SUB
    send(4'd2, 16'hAAAA, 16'h5555, 4'd0, 1'b1, 3'b000, 2'b01, 2'b10, 16'h1234, 16'h0004);
    busy_cycles(n, bad);
    check("fwd_res", 64'(bus.result_out), 64'h1230);
    check("fwd_c",   64'(bus.flags_out[2]), 0);
    @(posedge clk); #1;

    // Select 11 falls back to the register file; assorted ops and carries
    send(4'd1, 16'h0010, 16'h0020, 4'd0, 1'b1, 3'b000, 2'b11, 2'b11, 16'hFFFF, 16'hFFFF);
    send(4'd2, 16'h0001, 16'h0002, 4'd0, 1'b1, 3'b000);
    send(4'd3, 16'hF0F0, 16'h3C3C, 4'd0, 1'b1, 3'b000);
    send(4'd4, 16'h0F00, 16'h00F0, 4'd0, 1'b1, 3'b000);
    send(4'd5, 16'h00FF, 16'h0000, 4'd0, 1'b1, 3'b000);
    send(4'd6, 16'h8001, 16'h0000, 4'd1, 1'b1, 3'b000);
    send(4'd6, 16'h1234, 16'h0000, 4'd0, 1'b1, 3'b000);
    send(4'd7, 16'h0003, 16'h0000, 4'd1, 1'b1, 3'b000);
    send(4'd7, 16'h8000, 16'h0000, 4'd15, 1'b1, 3'b000);
    send(4'd9, 16'hFFFF, 16'h0000, 4'd0, 1'b1, 3'b000);
    send(4'd10, 16'h0000, 16'h0000, 4'd0, 1'b1, 3'b000);
    send(4'd11, 16'h1111, 16'h8765, 4'd0, 1'b1, 3'b000);
    send(4'd12, 16'h0000, 16'h0000, 4'd0, 1'b1, 3'b000);
    send(4'd1, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 3'b000);
    drain();

    // MUL timing and values
    send(4'd8, 16'h0102, 16'h0003, 4'd0, 1'b1, 3'b000);
    busy_cycles(n, bad);
    check("mul_wait",     64'(n), 16);
    check("mul_in_ready", 64'(bad), 0);
    check("mul_res",      64'(bus.result_out), 64'h0306);
    check("mul_c",        64'(bus.flags_out[2]), 0);
    @(posedge clk); #1;
    send(4'd8, 16'h8000, 16'h0002, 4'd0, 1'b1, 3'b000);
    busy_cycles(n, bad);
    check("mul2_res",   64'(bus.result_out), 64'h0000);
    check("mul2_flags", 64'(bus.flags_out), 64'b101);
    drain();

    // Backpressure: hold for 5 cycles, then back-to-back load
    bus.out_ready = 1'b0;
    send(4'd1, 16'h0005, 16'h0006, 4'd0, 1'b0, 3'b000);
    busy_cycles(n, bad);
    held = bus.result_out;
    check("bp_val", 64'(held), 64'd11);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.result_out !== held || bus.in_ready || !bus.out_valid) bad++;
    end
    check("bp_hold", 64'(bad), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(4'd1, 16'h0001, 16'h0002, 4'd0, 1'b0, 3'b000);
    check("b2b_valid", 64'(bus.out_valid), 1);
    check("b2b_res",   64'(bus.result_out), 64'd3);
    drain();

    // Flag restore then branches
    bus.flags_in = 3'b001; bus.flag_restore = 1'b1;
    @(posedge clk); #1;
    bus.flag_restore = 1'b0;
    m_flags = 3'b001;
    check("restore", 64'(bus.flags_out), 64'b001);
    send(4'd0, 16'h0040, 16'h0000, 4'd0, 1'b0, 3'b001);
    check("jz_taken",  64'(bus.branch_taken), 1);
    check("jz_target", 64'(bus.branch_target), 64'h0000_0040);
    send(4'd0, 16'h0041, 16'h0000, 4'd0, 1'b0, 3'b010);
    send(4'd0, 16'h0042, 16'h0000, 4'd0, 1'b0, 3'b011);
    send(4'd0, 16'h0001, 16'h0000, 4'd0, 1'b0, 3'b100, 2'b01, 2'b00, 16'h0ABC, 16'h0);
    send(4'd0, 16'h0043, 16'h0000, 4'd0, 1'b0, 3'b101);
    drain();

    // Flush on cycle 3 of a MUL
    saved = m_flags;
    send(4'd8, 16'h0003, 16'h0005, 4'd0, 1'b1, 3'b100);
    void'(q.pop_back());
    m_flags = saved;
    repeat (2) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.alu_op = 4'd1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("flush_no_out", 64'(bad), 0);
    check("flush_flags",  64'(bus.flags_out), 64'(saved));
    check("flush_idle",   64'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Reset in the middle of a MUL
    send(4'd8, 16'h0007, 16'h0009, 4'd0, 1'b1, 3'b000);
    q.delete();
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    check("mrst_out_valid", 64'(bus.out_valid), 0);
    check("mrst_flags",     64'(bus.flags_out), 0);
    check("mrst_in_ready",  64'(bus.in_ready), 0);
    m_flags = 3'b000;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mrst_rel_ready", 64'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Random mix of all opcodes, selects and jumps
    for (int i = 0; i < 30; i++) begin
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
Parametrised, handshaked successor to the single-cycle execute stage. It takes one decoded instruction per accepted transfer and selects forwarded operands. Single-cycle ops complete in 1 cycle; MUL runs on an iterative shift-add datapath over DATA_W cycles. The block owns the CNZ flag register, evaluates branches, and drives a valid/ready EX/MEM output register. It sits between the ID/EX register and the memory stage and supports stall and flush.

Parameters:
DATA_W, 16, operand/result width (>=4)
PC_W, 32, program counter width
RA_W, 3, register address width
SB_W, 8, opaque sideband control bits passed to memory stage unchanged

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  block accepts instruction this cycle
alu_op  in  4  operation code (see Behaviour)
shamt  in  4  shift amount
src1, src2  in  DATA_W each  register-file operands (Rdest, Rsrc)
fwd_sel1, fwd_sel2  in  2 each  00 regfile, 01 ex_mem_data, 10 mem_wb_data, 11 regfile
ex_mem_data, mem_wb_data  in  DATA_W each  forwarding sources
flag_en  in  1  op updates flags
jump_sel  in  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JMP
pc_in  in  PC_W  instruction PC
wr_addr_in  in  RA_W  destination register
sb_in  in  SB_W  sideband
flush  in  1  synchronous kill of in-flight and output state
flag_restore  in  1  load flags from flags_in
flags_in  in  3  {C,N,Z} restore value
out_valid  out  1  output register holds result
out_ready  in  1  downstream accepts
result_out  out  DATA_W  ALU result
flags_out  out  3  current flag register {C,N,Z}
branch_taken  out  1  registered with result
branch_target  out  PC_W  zero-extended forwarded src1
pc_out, wr_addr_out, sb_out  out  PC_W/RA_W/SB_W  passed through with result

Behaviour:
- Reset (reset=0, async): state IDLE; all output registers, flags_out, counters = 0; out_valid=0. in_ready=0 while reset asserted.
- Operands: op1/op2 chosen by fwd_sel at acceptance and latched for MUL.
- alu_op: 0000 pass op1; 0001 ADD; 0010 SUB (op1-op2, C=borrow); 0011 AND; 0100 OR; 0101 NOT op1; 0110 SHL op1 by shamt; 0111 SHR logical; 1000 MUL (low DATA_W of op1*op2); 1001 INC op1; 1010 DEC op1; 1011 pass op2; others = pass op1, flags unchanged.
- Flags: Z=(result==0), N=result[DATA_W-1]. C = carry-out for ADD/INC, borrow for SUB/DEC, last bit shifted out for shifts (shamt=0 -> C unchanged), high-product-nonzero for MUL. Logic ops preserve C. Flags are written on the same edge result_out loads, only if flag_en=1.
- Flag priority: flag_restore > flush > op update.
- Branch: evaluated at acceptance against flags_out before this op's update. JMP is always taken; codes 101-111 are not taken.
- Accept: transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- FSM IDLE: on a non-MUL accept, the output registers load next edge (latency 1) and out_valid=1. On a MUL accept, go to MUL_BUSY with cnt=0.
- FSM MUL_BUSY: one shift-add step per cycle. After DATA_W steps, load the output registers and return to IDLE (latency DATA_W+1). The block enters MUL_BUSY only when the output register is free, so completion never collides with a held result.
- Output: out_valid clears on out_valid && out_ready unless a new result loads the same edge. In that case out_valid stays 1 and the contents are replaced. Held contents are stable while out_ready=0.
- Flush: next edge -> IDLE, out_valid=0, branch_taken=0, multiply aborted, flags not updated by the killed op. An instruction presented with flush is not accepted.
- Reset mid-MUL: immediate abort to reset values.

Test Plan:
- Reset check: assert reset low mid-MUL -> out_valid=0, flags_out=000, in_ready=0; release -> in_ready=1 next cycle.
- ADD overflow: ADD 0xFFFF+0x0001, flag_en=1 -> result_out=0x0000, flags {C,N,Z}=101, out_valid 1 cycle after accept.
- Forwarding: fwd_sel1=01 with ex_mem_data=0x1234, fwd_sel2=10 with mem_wb_data=0x0004, SUB -> result_out=0x1230, C=0.
- MUL timing: MUL 0x0102*0x0003 -> in_ready=0 for 16 cycles, result_out=0x0306 at cycle 17, C=0. Also 0x8000*0x0002 -> result_out=0x0000, Z=1, C=1.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, result_out held 5 cycles; out_ready=1 with in_valid=1 -> next result loads back-to-back.
- Branch and flush: flags Z=1, JZ with src1=0x0040 -> branch_taken=1, branch_target=0x00000040. Flush on cycle 3 of a MUL -> out_valid stays 0, flags unchanged.
